// File: rtl/storage_load_sequencer_pkg.sv
// Shared types for the storage load sequencer: host word tags, command opcodes,
// sequencer states and sticky error bit positions.
package storage_loader_pkg;

  typedef enum logic [1:0] {
    TAG_CODE  = 2'd0,
    TAG_INPUT = 2'd1,
    TAG_LABEL = 2'd2,
    TAG_CMD   = 2'd3
  } tag_e;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOC_RST = 2'd1,
    ST_CODE_EN = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  localparam int ERR_CODE  = 0;
  localparam int ERR_INPUT = 1;
  localparam int ERR_LABEL = 2;

endpackage

// File: rtl/storage_load_sequencer_row_layer_counter.sv
// Row/layer address generator for one row-oriented storage stream; the layer
// index saturates at LAYERS, which is reported as full.
module row_layer_counter #(
  parameter int ROWS   = 16,
  parameter int LAYERS = 8,
  parameter int IDX_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] layer,
  output logic             full
);

  logic [IDX_W-1:0] row_r;
  logic [IDX_W-1:0] layer_r;

  // Row advances per write and wraps into the next layer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r   <= {IDX_W{1'b0}};
      layer_r <= {IDX_W{1'b0}};
    end else if (clear) begin
      row_r   <= {IDX_W{1'b0}};
      layer_r <= {IDX_W{1'b0}};
    end else if (inc && !full) begin
      if (row_r == IDX_W'(ROWS - 1)) begin
        row_r   <= {IDX_W{1'b0}};
        layer_r <= layer_r + IDX_W'(1);
      end else begin
        row_r   <= row_r + IDX_W'(1);
        layer_r <= layer_r;
      end
    end else begin
      row_r   <= row_r;
      layer_r <= layer_r;
    end
  end

  assign row   = row_r;
  assign layer = layer_r;
  assign full  = (layer_r == IDX_W'(LAYERS));

endmodule

// File: rtl/storage_load_sequencer.sv
// Host word stream to storage write pulses plus run sequencing for data_path.
// Optional sticky overflow flags and err port: define STORAGE_LOADER_ERR_EN.
module storage_load_sequencer
  import storage_loader_pkg::*;
#(
  parameter int DATA_W     = 48,
  parameter int CODE_W     = 12,
  parameter int IDX_W      = 32,
  parameter int CODE_DEPTH = 256,
  parameter int ROWS       = 16,
  parameter int LAYERS     = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        s_tag,
  input  logic [DATA_W-1:0] s_data,
  input  logic              ctrl_done,
  output logic [IDX_W-1:0]  code_write_line,
  output logic [CODE_W-1:0] code_write_data,
  output logic              code_is_write,
  output logic [IDX_W-1:0]  input_write_layer_index,
  output logic [IDX_W-1:0]  input_write_row_index,
  output logic [DATA_W-1:0] input_write_data,
  output logic              input_is_write,
  output logic [IDX_W-1:0]  label_write_layer_index,
  output logic [IDX_W-1:0]  label_write_row_index,
  output logic [DATA_W-1:0] label_write_data,
  output logic              label_is_write,
  output logic              locator_reset,
  output logic              code_storage_enable,
  output logic              controller_enable,
  output logic              busy
`ifdef STORAGE_LOADER_ERR_EN
  ,
  output logic [2:0]        err
`endif
);

  state_e            state_r, state_next_s;
  tag_e              tag_s;
  op_e               op_s;
  logic              accept_s, clear_s;
  logic              code_wr_s, input_wr_s, label_wr_s, code_full_s;
  logic [IDX_W-1:0]  cl_r;
  logic [IDX_W-1:0]  input_row_s, input_layer_s, label_row_s, label_layer_s;
  logic              input_full_s, label_full_s;
  logic              s_ready_r, busy_r, locator_reset_r;
  logic              code_storage_enable_r, controller_enable_r;
  logic              code_is_write_r, input_is_write_r, label_is_write_r;
  logic [IDX_W-1:0]  code_write_line_r;
  logic [CODE_W-1:0] code_write_data_r;
  logic [IDX_W-1:0]  input_layer_r, input_row_r, label_layer_r, label_row_r;
  logic [DATA_W-1:0] input_data_r, label_data_r;

  assign accept_s    = s_valid & s_ready_r;
  assign tag_s       = tag_e'(s_tag);
  assign op_s        = op_e'(s_data[1:0]);
  assign code_full_s = (cl_r == IDX_W'(CODE_DEPTH));

  // Beat decode and next-state selection
  always_comb begin
    state_next_s = state_r;
    clear_s      = 1'b0;
    code_wr_s    = 1'b0;
    input_wr_s   = 1'b0;
    label_wr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (tag_s)
            TAG_CODE:  code_wr_s  = ~code_full_s;
            TAG_INPUT: input_wr_s = ~input_full_s;
            TAG_LABEL: label_wr_s = ~label_full_s;
            TAG_CMD: begin
              clear_s = (op_s == OP_CLEAR);
              if (op_s == OP_START) state_next_s = ST_LOC_RST;
              else                  state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOC_RST: state_next_s = ST_CODE_EN;
      ST_CODE_EN: state_next_s = ST_RUN;
      ST_RUN: begin
        // Data beats in RUN are acked and dropped; only STOP or ctrl_done end the run
        if (ctrl_done || (accept_s && tag_s == TAG_CMD && op_s == OP_STOP)) state_next_s = ST_IDLE;
        else                                                               state_next_s = ST_RUN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and state-derived control outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r               <= ST_IDLE;
      s_ready_r             <= 1'b0;
      busy_r                <= 1'b0;
      locator_reset_r       <= 1'b0;
      code_storage_enable_r <= 1'b0;
      controller_enable_r   <= 1'b0;
    end else begin
      state_r               <= state_next_s;
      s_ready_r             <= (state_next_s == ST_IDLE) || (state_next_s == ST_RUN);
      busy_r                <= (state_next_s != ST_IDLE);
      locator_reset_r       <= (state_r == ST_LOC_RST);
      code_storage_enable_r <= (state_next_s == ST_RUN);
      controller_enable_r   <= (state_r == ST_RUN) && (state_next_s == ST_RUN);
    end
  end

  // Code line counter and code write port
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cl_r              <= {IDX_W{1'b0}};
      code_is_write_r   <= 1'b0;
      code_write_line_r <= {IDX_W{1'b0}};
      code_write_data_r <= {CODE_W{1'b0}};
    end else begin
      if (clear_s)        cl_r <= {IDX_W{1'b0}};
      else if (code_wr_s) cl_r <= cl_r + IDX_W'(1);
      else                cl_r <= cl_r;
      code_is_write_r <= code_wr_s;
      if (code_wr_s) begin
        code_write_line_r <= cl_r;
        code_write_data_r <= s_data[CODE_W-1:0];
      end
    end
  end

  row_layer_counter #(.ROWS(ROWS), .LAYERS(LAYERS), .IDX_W(IDX_W)) u_input_cnt (
    .clk(clk_clk), .rst_n(reset_reset_n), .inc(input_wr_s), .clear(clear_s),
    .row(input_row_s), .layer(input_layer_s), .full(input_full_s)
  );

  row_layer_counter #(.ROWS(ROWS), .LAYERS(LAYERS), .IDX_W(IDX_W)) u_label_cnt (
    .clk(clk_clk), .rst_n(reset_reset_n), .inc(label_wr_s), .clear(clear_s),
    .row(label_row_s), .layer(label_layer_s), .full(label_full_s)
  );

  // Input and label write ports capture the pre-increment address
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      input_is_write_r <= 1'b0;
      input_layer_r    <= {IDX_W{1'b0}};
      input_row_r      <= {IDX_W{1'b0}};
      input_data_r     <= {DATA_W{1'b0}};
      label_is_write_r <= 1'b0;
      label_layer_r    <= {IDX_W{1'b0}};
      label_row_r      <= {IDX_W{1'b0}};
      label_data_r     <= {DATA_W{1'b0}};
    end else begin
      input_is_write_r <= input_wr_s;
      label_is_write_r <= label_wr_s;
      if (input_wr_s) begin
        input_layer_r <= input_layer_s;
        input_row_r   <= input_row_s;
        input_data_r  <= s_data;
      end
      if (label_wr_s) begin
        label_layer_r <= label_layer_s;
        label_row_r   <= label_row_s;
        label_data_r  <= s_data;
      end
    end
  end

`ifdef STORAGE_LOADER_ERR_EN
  logic [2:0] ovf_s;
  logic [2:0] err_r;

  // Dropped-beat detection per stream
  always_comb begin
    ovf_s = 3'b000;
    if (accept_s) begin
      case (tag_s)
        TAG_CODE:  ovf_s[ERR_CODE]  = (state_r == ST_RUN) | code_full_s;
        TAG_INPUT: ovf_s[ERR_INPUT] = (state_r == ST_RUN) | input_full_s;
        TAG_LABEL: ovf_s[ERR_LABEL] = (state_r == ST_RUN) | label_full_s;
        default:   ovf_s = 3'b000;
      endcase
    end else begin
      ovf_s = 3'b000;
    end
  end

  // Sticky overflow flags
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) err_r <= 3'b000;
    else if (clear_s)   err_r <= 3'b000;
    else                err_r <= err_r | ovf_s;
  end

  assign err = err_r;
`endif

  assign s_ready                 = s_ready_r;
  assign busy                    = busy_r;
  assign locator_reset           = locator_reset_r;
  assign code_storage_enable     = code_storage_enable_r;
  assign controller_enable       = controller_enable_r;
  assign code_is_write           = code_is_write_r;
  assign code_write_line         = code_write_line_r;
  assign code_write_data         = code_write_data_r;
  assign input_is_write          = input_is_write_r;
  assign input_write_layer_index = input_layer_r;
  assign input_write_row_index   = input_row_r;
  assign input_write_data        = input_data_r;
  assign label_is_write          = label_is_write_r;
  assign label_write_layer_index = label_layer_r;
  assign label_write_row_index   = label_row_r;
  assign label_write_data        = label_data_r;

endmodule

// File: tb/tb_storage_load_sequencer.sv
// Directed bench for storage_load_sequencer; err checks compile in with STORAGE_LOADER_ERR_EN.
module tb_storage_load_sequencer;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_tag;
  logic [47:0] s_data;
  logic        ctrl_done;
  logic [31:0] code_write_line;
  logic [11:0] code_write_data;
  logic        code_is_write;
  logic [31:0] input_write_layer_index, input_write_row_index;
  logic [47:0] input_write_data;
  logic        input_is_write;
  logic [31:0] label_write_layer_index, label_write_row_index;
  logic [47:0] label_write_data;
  logic        label_is_write;
  logic        locator_reset, code_storage_enable, controller_enable, busy;
`ifdef STORAGE_LOADER_ERR_EN
  logic [2:0]  err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_clk = ~clk_clk;

  storage_load_sequencer dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_tag(s_tag), .s_data(s_data),
    .ctrl_done(ctrl_done),
    .code_write_line(code_write_line), .code_write_data(code_write_data),
    .code_is_write(code_is_write),
    .input_write_layer_index(input_write_layer_index),
    .input_write_row_index(input_write_row_index),
    .input_write_data(input_write_data), .input_is_write(input_is_write),
    .label_write_layer_index(label_write_layer_index),
    .label_write_row_index(label_write_row_index),
    .label_write_data(label_write_data), .label_is_write(label_is_write),
    .locator_reset(locator_reset), .code_storage_enable(code_storage_enable),
    .controller_enable(controller_enable), .busy(busy)
`ifdef STORAGE_LOADER_ERR_EN
    , .err(err)
`endif
  );

  task automatic drive(input logic v, input logic [1:0] tag, input logic [47:0] data);
    s_valid = v;
    s_tag   = tag;
    s_data  = data;
  endtask

  // {locator_reset, code_storage_enable, controller_enable, busy, s_ready} through a START
  task automatic check_start_seq(input string name);
    logic [4:0] exp_seq [4];
    exp_seq[0] = 5'b00010;
    exp_seq[1] = 5'b10010;
    exp_seq[2] = 5'b01011;
    exp_seq[3] = 5'b01111;
    drive(1'b1, 2'd3, 48'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_clk);
      drive(1'b0, 2'd0, 48'd0);
      checks++;
      if ({locator_reset, code_storage_enable, controller_enable, busy, s_ready} !== exp_seq[k]) begin
        errors++;
        $display("FAIL %s edge N+%0d: got %b expected %b", name, k,
                 {locator_reset, code_storage_enable, controller_enable, busy, s_ready}, exp_seq[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    ctrl_done     = 1'b0;
    drive(1'b0, 2'd0, 48'd0);
    repeat (2) @(negedge clk_clk);
    checks++;
    if ({code_is_write, input_is_write, label_is_write, locator_reset, code_storage_enable,
         controller_enable, busy, s_ready, code_write_line, input_write_row_index} !== 72'd0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero output in reset");
    end
`ifdef STORAGE_LOADER_ERR_EN
    checks++;
    if (err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", err); end
`endif
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    checks++;
    if ({s_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got ready/busy %b expected 10", {s_ready, busy});
    end
  endtask

  task automatic test_code_burst();
    drive(1'b1, 2'd0, 48'h0A1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_clk);
      checks++;
      if ({code_is_write, code_write_line, code_write_data} !== {1'b1, 32'(i), 12'(12'h0A1 + i)}) begin
        errors++;
        $display("FAIL code_write[%0d]: got %b/%0d/%h expected 1/%0d/%h", i, code_is_write,
                 code_write_line, code_write_data, i, 12'(12'h0A1 + i));
      end
      checks++;
      if ({input_is_write, label_is_write} !== 2'b00) begin
        errors++; $display("FAIL code_cross_write[%0d]: got %b expected 00", i, {input_is_write, label_is_write});
      end
      if (i < 2) drive(1'b1, 2'd0, 48'(48'h0A2 + i));
      else       drive(1'b0, 2'd0, 48'd0);
    end
    @(negedge clk_clk);
    checks++;
    if (code_is_write !== 1'b0) begin errors++; $display("FAIL code_pulse_end: got 1 expected 0"); end
  endtask

  task automatic test_input_wrap();
    drive(1'b1, 2'd1, 48'd0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_clk);
      checks++;
      if ({input_is_write, input_write_layer_index, input_write_row_index, input_write_data}
          !== {1'b1, 32'(i / 16), 32'(i % 16), 48'(i)}) begin
        errors++;
        $display("FAIL input_write[%0d]: got %b L%0d R%0d D%0h expected 1 L%0d R%0d D%0h", i,
                 input_is_write, input_write_layer_index, input_write_row_index, input_write_data,
                 i / 16, i % 16, i);
      end
      checks++;
      if (label_is_write !== 1'b0) begin errors++; $display("FAIL input_label_idle[%0d]: got 1 expected 0", i); end
      if (i < 16) drive(1'b1, 2'd1, 48'(i + 1));
      else        drive(1'b0, 2'd0, 48'd0);
    end
  endtask

  task automatic test_start_run();
    check_start_seq("start_seq");
    drive(1'b1, 2'd0, 48'h123);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL run_ready: got 0 expected 1"); end
    @(negedge clk_clk);
    drive(1'b0, 2'd0, 48'd0);
    checks++;
    if ({code_is_write, code_storage_enable, controller_enable, busy} !== 4'b0111) begin
      errors++;
      $display("FAIL run_code_drop: got %b expected 0111",
               {code_is_write, code_storage_enable, controller_enable, busy});
    end
`ifdef STORAGE_LOADER_ERR_EN
    checks++;
    if (err !== 3'b001) begin errors++; $display("FAIL run_code_err: got %b expected 001", err); end
`endif
    ctrl_done = 1'b1;
    @(negedge clk_clk);
    ctrl_done = 1'b0;
    checks++;
    if ({locator_reset, code_storage_enable, controller_enable, busy, s_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL ctrl_done_stop: got %b expected 00001",
               {locator_reset, code_storage_enable, controller_enable, busy, s_ready});
    end
  endtask

  task automatic test_label_ovf();
    drive(1'b1, 2'd2, 48'h100);
    for (int i = 0; i < 129; i++) begin
      @(negedge clk_clk);
      if (i < 128) begin
        checks++;
        if ({label_is_write, label_write_layer_index, label_write_row_index, label_write_data}
            !== {1'b1, 32'(i / 16), 32'(i % 16), 48'(48'h100 + i)}) begin
          errors++;
          $display("FAIL label_write[%0d]: got %b L%0d R%0d D%0h expected 1 L%0d R%0d", i,
                   label_is_write, label_write_layer_index, label_write_row_index,
                   label_write_data, i / 16, i % 16);
        end
      end else begin
        checks++;
        if (label_is_write !== 1'b0) begin errors++; $display("FAIL label_ovf_write: got 1 expected 0"); end
`ifdef STORAGE_LOADER_ERR_EN
        checks++;
        if (err !== 3'b101) begin errors++; $display("FAIL label_ovf_err: got %b expected 101", err); end
`endif
      end
      if (i < 128) drive(1'b1, 2'd2, 48'(48'h100 + i + 1));
      else         drive(1'b1, 2'd3, 48'd0);
    end
    @(negedge clk_clk);
    drive(1'b1, 2'd2, 48'hABCD);
`ifdef STORAGE_LOADER_ERR_EN
    checks++;
    if (err !== 3'b000) begin errors++; $display("FAIL clear_err: got %b expected 000", err); end
`endif
    @(negedge clk_clk);
    drive(1'b1, 2'd0, 48'h555);
    checks++;
    if ({label_is_write, label_write_layer_index, label_write_row_index, label_write_data}
        !== {1'b1, 32'd0, 32'd0, 48'hABCD}) begin
      errors++;
      $display("FAIL clear_label: got %b L%0d R%0d D%0h expected 1 L0 R0 Dabcd", label_is_write,
               label_write_layer_index, label_write_row_index, label_write_data);
    end
    @(negedge clk_clk);
    drive(1'b0, 2'd0, 48'd0);
    checks++;
    if ({code_is_write, code_write_line, code_write_data} !== {1'b1, 32'd0, 12'h555}) begin
      errors++;
      $display("FAIL clear_code: got %b/%0d/%h expected 1/0/555", code_is_write, code_write_line, code_write_data);
    end
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 2'd1, 48'd7);
    @(negedge clk_clk);
    drive(1'b0, 2'd0, 48'd0);
    check_start_seq("pre_reset_seq");
    #2 reset_reset_n = 1'b0;
    #1;
    checks++;
    if ({locator_reset, code_storage_enable, controller_enable, busy, s_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 00000",
               {locator_reset, code_storage_enable, controller_enable, busy, s_ready});
    end
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    drive(1'b1, 2'd1, 48'd9);
    @(negedge clk_clk);
    drive(1'b0, 2'd0, 48'd0);
    checks++;
    if ({input_is_write, input_write_layer_index, input_write_row_index} !== {1'b1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_counters: got %b L%0d R%0d expected 1 L0 R0", input_is_write,
               input_write_layer_index, input_write_row_index);
    end
    check_start_seq("post_reset_seq");
    drive(1'b1, 2'd3, 48'd2);
    ctrl_done = 1'b1;
    @(negedge clk_clk);
    drive(1'b0, 2'd0, 48'd0);
    ctrl_done = 1'b0;
    checks++;
    if ({locator_reset, code_storage_enable, controller_enable, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL stop_and_done: got %b expected 0000",
               {locator_reset, code_storage_enable, controller_enable, busy});
    end
    drive(1'b1, 2'd3, 48'd3);
    @(negedge clk_clk);
    drive(1'b1, 2'd3, 48'd2);
    @(negedge clk_clk);
    drive(1'b0, 2'd0, 48'd0);
    checks++;
    if ({locator_reset, code_storage_enable, busy, s_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL idle_ignored_ops: got %b expected 0001",
               {locator_reset, code_storage_enable, busy, s_ready});
    end
  endtask

  initial begin
    test_reset();
    test_code_burst();
    test_input_wrap();
    test_start_run();
    test_label_ovf();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/storage_load_sequencer.md
# storage_load_sequencer

Front-end sequencer for `data_path`. It accepts a tagged word stream from the host and turns it into timed write pulses on the code, input and label storage write interfaces. Row and layer indices are generated automatically. On a start command it pulses the matrix storage locator reset, then enables code storage and, one cycle later, the controller, until the run ends.

## Interface
Parameters:
- `DATA_W`, 48: input/label row width (three 16-bit fields).
- `CODE_W`, 12: code word width.
- `IDX_W`, 32: line/row/layer index width.
- `CODE_DEPTH`, 256: code lines available.
- `ROWS`, 16: rows per layer (input and label).
- `LAYERS`, 8: layers available (input and label).

Ports (one clock; reset is asynchronous and active-low):
- `clk_clk` in 1: clock.
- `reset_reset_n` in 1: async active-low reset.
- `s_valid` in 1: host word valid.
- `s_ready` out 1: host word accepted when `s_valid & s_ready`.
- `s_tag` in 2: word kind: 0 code, 1 input row, 2 label row, 3 command.
- `s_data` in `DATA_W`: payload. Code uses [11:0]; command opcode is [1:0].
- `ctrl_done` in 1: controller finished run.
- `code_write_line` out `IDX_W`, `code_write_data` out `CODE_W`, `code_is_write` out 1.
- `input_write_layer_index` out `IDX_W`, `input_write_row_index` out `IDX_W`, `input_write_data` out `DATA_W`, `input_is_write` out 1.
- `label_write_layer_index` out `IDX_W`, `label_write_row_index` out `IDX_W`, `label_write_data` out `DATA_W`, `label_is_write` out 1.
- `locator_reset` out 1: matrix storage locator reset pulse.
- `code_storage_enable` out 1.
- `controller_enable` out 1.
- `busy` out 1: state ≠ IDLE.
- `err` out 3 (only with `STORAGE_LOADER_ERR_EN`): sticky {label_ovf, input_ovf, code_ovf}.

## Operation
- States: IDLE, LOC_RST, CODE_EN, RUN.
  - IDLE --start--> LOC_RST.
  - LOC_RST → CODE_EN unconditionally.
  - CODE_EN → RUN unconditionally.
  - RUN --(stop | `ctrl_done`)--> IDLE.
- `s_ready`: 1 in IDLE and RUN; 0 in LOC_RST and CODE_EN.
- Code beat (IDLE): writes `s_data[11:0]` at code line counter `cl`, then `cl++`.
  - At `cl == CODE_DEPTH`: beat consumed, no write, `code_ovf` set.
- Input/label beat (IDLE): writes at (layer, row) of that stream's counter pair.
  - Row increments; at `ROWS-1` it wraps to 0 and layer increments.
  - Layer saturates at `LAYERS`; any beat there is consumed, not written, and sets that stream's ovf.
- Opcodes:
  - 0 CLEAR: all counters ← 0 and err ← 0. Honoured in IDLE only.
  - 1 START: honoured in IDLE only.
  - 2 STOP: honoured in RUN only.
  - 3 and unhonoured opcodes: ignored.
- In RUN, non-command beats are consumed and dropped, with no write. They set the matching ovf bit.
- Outputs per state:
  - `locator_reset` = 1 only in LOC_RST.
  - `code_storage_enable` = 1 in CODE_EN and RUN.
  - `controller_enable` = 1 in RUN only.
- Counters are not cleared by START; a rerun reuses loaded storage.

## Timing
- All outputs registered. Reset value of every output is 0; counters, state and err also reset to 0.
- Write latency: beat accepted at edge N → `*_is_write` high for exactly the cycle after edge N, with index/data stable in that cycle.
- Back-to-back beats give consecutive one-cycle write pulses with no bubble. Only one storage writes per cycle.
- START accepted at edge N:
  - `locator_reset` is high N+1..N+2 (one cycle).
  - `code_storage_enable` rises at N+2.
  - `controller_enable` rises at N+3.
- STOP or `ctrl_done` sampled at edge M in RUN: both enables low after M. If both occur together, one transition.
- Async reset mid-run: all enables drop immediately. State → IDLE and counters → 0.

## Configuration
- `STORAGE_LOADER_ERR_EN` defined: `err` port and sticky flags exist, cleared by reset or CLEAR.
- Not defined: no `err` port and no flag registers. Overflow/dropped beats are silently discarded; all other behaviour is identical.

## Structure
- `storage_loader_pkg`: tag enum (TAG_CODE, TAG_INPUT, TAG_LABEL, TAG_CMD), opcode enum (OP_CLEAR, OP_START, OP_STOP), state enum, and the err bit positions.
- Sub-module `row_layer_counter` (params `ROWS`, `LAYERS`, `IDX_W`; inputs inc, clear; outputs row, layer, full). It is instantiated twice, for input and label.

## Test plan
- Reset, then 3 code beats 0x0A1, 0x0A2, 0x0A3 → `code_is_write` pulses at lines 0, 1, 2 on consecutive cycles with matching data.
- `ROWS`=16: 17 input beats → the 17th writes layer 1, row 0; the label counters are unchanged.
- START in IDLE at edge N → `locator_reset` high one cycle at N+1, `code_storage_enable` at N+2, `controller_enable` at N+3. Then `ctrl_done` → all enables low the next cycle and `busy`=0.
- Code beat in RUN → no `code_is_write`; `err[0]`=1 (ERR_EN build), and the beat is still acked.
- `LAYERS`=8, `ROWS`=16: 129 label beats → 128 writes; the 129th sets `err[2]`. CLEAR → err=0 and the next label beat writes layer 0, row 0.
- Assert reset mid-RUN → enables low asynchronously, counters 0; the START after release repeats the exact N+1/N+2/N+3 sequence.
